// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : div_arbiter
// Desc     : Round-robin arbiter that shares one divider among P_NUM_REQ
//            requesters and returns each result on a valid/ready response
//            channel. Build option DIV_ARB_ZERO_BYPASS_EN answers divide-by-
//            zero locally (quotient all-ones, remainder = dividend).
// Revision : 1.0 - initial release
// ============================================================================
module div_arbiter #(
    parameter int P_WIDTH   = 32,
    parameter int P_NUM_REQ = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [P_NUM_REQ-1:0]           req_valid,
    output logic [P_NUM_REQ-1:0]           req_ready,
    input  logic [P_NUM_REQ*P_WIDTH-1:0]   req_dividend,
    input  logic [P_NUM_REQ*P_WIDTH-1:0]   req_divisor,
    output logic                           div_start,
    output logic [P_WIDTH-1:0]             div_dividend,
    output logic [P_WIDTH-1:0]             div_divisor,
    input  logic [P_WIDTH-1:0]             div_quotient,
    input  logic [P_WIDTH-1:0]             div_remainder,
    input  logic                           div_done,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [$clog2(P_NUM_REQ)-1:0]   rsp_id,
    output logic [P_WIDTH-1:0]             rsp_quotient,
    output logic [P_WIDTH-1:0]             rsp_remainder,
    output logic                           busy
);

    localparam int               c_IDW     = $clog2(P_NUM_REQ);
    localparam logic [c_IDW-1:0] c_LAST_ID = c_IDW'(P_NUM_REQ - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    logic [1:0]         r_state;
    logic [c_IDW-1:0]   r_rr_ptr;
    logic               r_div_start;
    logic [P_WIDTH-1:0] r_div_dividend;
    logic [P_WIDTH-1:0] r_div_divisor;
    logic               r_rsp_valid;
    logic [c_IDW-1:0]   r_rsp_id;
    logic [P_WIDTH-1:0] r_rsp_quotient;
    logic [P_WIDTH-1:0] r_rsp_remainder;

    logic               w_hi_found;
    logic [c_IDW-1:0]   w_hi_idx;
    logic [c_IDW-1:0]   w_lo_idx;
    logic [c_IDW-1:0]   w_grant_idx;
    logic               w_grant;
    logic [P_WIDTH-1:0] w_sel_dividend;
    logic [P_WIDTH-1:0] w_sel_divisor;
    logic [c_IDW-1:0]   w_next_ptr;

    // Lowest valid index at/above the pointer wins; otherwise wrap to the
    // lowest valid index overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = P_NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_lo_idx = i[c_IDW-1:0];
                if (i[c_IDW-1:0] >= r_rr_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = i[c_IDW-1:0];
                end
            end
        end
    end

    assign w_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_grant     = (r_state == c_ST_IDLE) && (|req_valid) && !rst;

    always_comb begin
        req_ready      = '0;
        w_sel_dividend = '0;
        w_sel_divisor  = '0;
        for (int i = 0; i < P_NUM_REQ; i++) begin
            if (w_grant_idx == i[c_IDW-1:0]) begin
                w_sel_dividend = req_dividend[i*P_WIDTH +: P_WIDTH];
                w_sel_divisor  = req_divisor[i*P_WIDTH +: P_WIDTH];
                req_ready[i]   = w_grant;
            end
        end
    end

    assign w_next_ptr = (r_rsp_id == c_LAST_ID) ? '0 : r_rsp_id + c_IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_rr_ptr        <= '0;
            r_div_start     <= 1'b0;
            r_div_dividend  <= '0;
            r_div_divisor   <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_id        <= '0;
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
        end else begin
            r_div_start <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant) begin
                        r_div_dividend <= w_sel_dividend;
                        r_div_divisor  <= w_sel_divisor;
                        r_rsp_id       <= w_grant_idx;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                        if (w_sel_divisor == '0) begin
                            r_rsp_quotient  <= '1;
                            r_rsp_remainder <= w_sel_dividend;
                            r_rsp_valid     <= 1'b1;
                            r_state         <= c_ST_RESP;
                        end else begin
                            r_div_start <= 1'b1;
                            r_state     <= c_ST_ISSUE;
                        end
`else
                        r_div_start <= 1'b1;
                        r_state     <= c_ST_ISSUE;
`endif
                    end
                end
                c_ST_ISSUE: begin
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (div_done) begin
                        r_rsp_quotient  <= div_quotient;
                        r_rsp_remainder <= div_remainder;
                        r_rsp_valid     <= 1'b1;
                        r_state         <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= w_next_ptr;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign div_start     = r_div_start;
    assign div_dividend  = r_div_dividend;
    assign div_divisor   = r_div_divisor;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_quotient  = r_rsp_quotient;
    assign rsp_remainder = r_rsp_remainder;
    assign busy          = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 The block SHALL have parameter P_WIDTH, default 32, giving the operand/result width in bits.
REQ-002 The block SHALL have parameter P_NUM_REQ, default 4, giving the requester count (2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, P_NUM_REQ bits: bit i high when requester i offers a division.
REQ-006 The block SHALL have port req_ready, output, P_NUM_REQ bits: one-hot or zero; bit i high grants requester i this cycle.
REQ-007 The block SHALL have port req_dividend, input, P_NUM_REQ*P_WIDTH bits: packed dividends, slice i = requester i.
REQ-008 The block SHALL have port req_divisor, input, P_NUM_REQ*P_WIDTH bits: packed divisors, slice i = requester i.
REQ-009 The block SHALL have ports div_start (output, 1), div_dividend (output, P_WIDTH) and div_divisor (output, P_WIDTH): command to the shared divider.
REQ-010 The block SHALL have ports div_quotient (input, P_WIDTH), div_remainder (input, P_WIDTH) and div_done (input, 1): divider result; div_done is a 1-cycle pulse.
REQ-011 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_id (output, $clog2(P_NUM_REQ)), rsp_quotient (output, P_WIDTH) and rsp_remainder (output, P_WIDTH): the response channel.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-014 In IDLE with any req_valid bit set, req_ready SHALL combinationally select the first valid index at or above rr_ptr, wrapping modulo P_NUM_REQ.
REQ-015 On that IDLE handshake cycle, the block SHALL latch the granted operands into div_dividend/div_divisor, latch the index into rsp_id, and move to ISSUE.
REQ-016 req_ready SHALL be all-zero in every state other than IDLE.
REQ-017 In ISSUE, div_start SHALL be high for exactly one cycle, followed by an unconditional move to WAIT.
REQ-018 In WAIT, the block SHALL, on div_done, capture div_quotient and div_remainder into rsp_quotient/rsp_remainder and move to RESP; with no div_done it SHALL hold indefinitely.
REQ-019 div_done SHALL be ignored in every state other than WAIT.
REQ-020 In RESP, rsp_valid SHALL be high; rsp_id/rsp_quotient/rsp_remainder SHALL hold stable until rsp_valid and rsp_ready are both high.
REQ-021 On the RESP handshake, the block SHALL set rr_ptr to (rsp_id+1) mod P_NUM_REQ and return to IDLE; a new grant SHALL occur no earlier than the following cycle.
REQ-022 div_dividend and div_divisor SHALL hold stable from ISSUE until the return to IDLE.
REQ-023 Round-robin SHALL guarantee that a continuously valid requester is granted within P_NUM_REQ transactions.
REQ-024 Latency from the grant cycle to rsp_valid SHALL be 2 cycles plus the divider's start-to-done latency.

Reset
REQ-025 On a cycle with rst high, the block SHALL enter IDLE and clear rr_ptr, div_start, rsp_valid, req_ready, div_dividend, div_divisor, rsp_id, rsp_quotient and rsp_remainder to 0; busy SHALL be 0.
REQ-026 Reset mid-transaction SHALL discard the transaction, and no response SHALL be produced for it.
REQ-027 The divider's rst_n SHALL be driven by ~rst at integration so that both blocks reset together.

Configuration
REQ-028 With macro DIV_ARB_ZERO_BYPASS_EN defined, a grant with divisor 0 SHALL skip ISSUE/WAIT and go directly to RESP with rsp_quotient all-ones and rsp_remainder equal to the dividend, and div_start SHALL never pulse for it.
REQ-029 With DIV_ARB_ZERO_BYPASS_EN undefined, a zero divisor SHALL follow the normal ISSUE/WAIT path, and the response SHALL reflect the divider's output.

Verification
REQ-030 The bench SHALL drive reset with req_valid=4'b1111 held and check req_ready=0, rsp_valid=0, busy=0, with the first grant after reset going to requester 0.
REQ-031 The bench SHALL drive requester 2 with 100/7 and a divider model of 34-cycle latency, and check rsp_id=2, quotient 14, remainder 2, and rsp_valid exactly 36 cycles after the grant.
REQ-032 The bench SHALL hold all four requesters valid for 8 transactions, and check the grant order 0,1,2,3,0,1,2,3.
REQ-033 The bench SHALL hold rsp_ready low for 10 cycles in RESP, and check the outputs are stable, req_ready stays 0, and exactly one response is accepted on release.
REQ-034 The bench SHALL send divisor 0 with dividend 0x1234, and check that with the macro defined there is no div_start and the response is 0xFFFFFFFF/0x1234, and that without the macro div_start pulses once.
REQ-035 The bench SHALL assert rst in WAIT and then inject div_done, and check that no rsp_valid follows and that the block is IDLE with rr_ptr=0.
